spi_slave_ctrl: RTL and testbench

SPI slave front-end directly upstream of the dual-port synchronous RAM. It deserialises MOSI frames into 10-bit command words and presents each word to the RAM as `rx_data` with a one-cycle `rx_valid` pulse. For read-data frames it waits for the RAM's `tx_valid`/`tx_data` response and serialises the 8-bit result on MISO. The SPI clock is the system clock `clk`.

---
 rtl/spi_pkg.sv | 37 +++
 rtl/spi_slave_ctrl_if.sv | 30 +++
 rtl/spi_miso_ser.sv | 58 +++++
 rtl/spi_slave_ctrl.sv | 129 ++++++++++++
 tb/tb_spi_slave_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg : shared types and constants for the SPI slave front-end
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

    localparam int FRAME_W   = 10;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = $clog2(FRAME_W + 1);
    localparam int SER_CNT_W = $clog2(DATA_W);

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

    function automatic logic is_read_op(input logic [1:0] op);
        return (op == OP_RD_ADDR) || (op == OP_RD_DATA);
    endfunction

    function automatic logic is_write_op(input logic [1:0] op);
        return (op == OP_WR_ADDR) || (op == OP_WR_DATA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_slave_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_slave_ctrl_if : SPI pins plus RAM-side command/read-data handshake
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface spi_slave_ctrl_if;
    import spi_pkg::*;

    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

endinterface

`default_nettype wire

// File: rtl/spi_miso_ser.sv
// ---------------------------------------------------------------------------
// spi_miso_ser : loads a read-data byte on a strobe, shifts it out MSB first
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_miso_ser
    import spi_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_load,
    input  wire logic              i_abort,
    input  wire logic [DATA_W-1:0] i_data,
    output logic                   o_miso,
    output logic                   o_done
);

    logic [DATA_W-1:0]    r_shift;
    logic [SER_CNT_W-1:0] r_cnt;
    logic                 r_busy;
    logic                 r_miso;

    // The MSB goes straight to the output on load, so r_cnt counts the bits still to come.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_miso  <= 1'b0;
        end else if (i_abort) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_miso  <= 1'b0;
        end else if (i_load) begin
            r_miso  <= i_data[DATA_W-1];
            r_shift <= {i_data[DATA_W-2:0], 1'b0};
            r_cnt   <= SER_CNT_W'(DATA_W - 1);
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                r_miso  <= r_shift[DATA_W-1];
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                r_cnt   <= r_cnt - SER_CNT_W'(1);
            end else begin
                r_miso <= 1'b0;
                r_busy <= 1'b0;
            end
        end
    end

    assign o_miso = r_miso;
    assign o_done = !r_busy;

endmodule

`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
// ---------------------------------------------------------------------------
// spi_slave_ctrl : SPI slave FSM, MOSI deserialiser and RAM handshake
// Optional assertions/covers: define SPI_SLAVE_SVA_EN.          Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_slave_ctrl
    import spi_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    spi_slave_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_W);

    spi_state_e         r_state;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [FRAME_W-2:0] r_shift;
    logic [FRAME_W-1:0] r_rx_data;
    logic               r_rx_valid;
    logic               r_rd_addr_pending;
    logic               r_wait_tx;

    logic               w_ser_load;
    logic               w_ser_done;
    logic               w_miso;

    assign w_ser_load = !bus.SS_n && (r_state == READ_DATA) && r_wait_tx
                        && bus.tx_valid && w_ser_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_bit_cnt         <= '0;
            r_shift           <= '0;
            r_rx_data         <= '0;
            r_rx_valid        <= 1'b0;
            r_rd_addr_pending <= 1'b0;
            r_wait_tx         <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (bus.SS_n) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_wait_tx <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state   <= CHK_CMD;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                    CHK_CMD: begin
                        r_shift   <= {r_shift[FRAME_W-3:0], bus.MOSI};
                        r_bit_cnt <= CNT_W'(1);
                        if (!bus.MOSI)
                            r_state <= WRITE;
                        else if (r_rd_addr_pending)
                            r_state <= READ_DATA;
                        else
                            r_state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        // Counter parks at FRAME_END so trailing MOSI bits are ignored.
                        if (r_bit_cnt < FRAME_END) begin
                            r_shift   <= {r_shift[FRAME_W-3:0], bus.MOSI};
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            if (r_bit_cnt == LAST_BIT) begin
                                r_rx_data  <= {r_shift, bus.MOSI};
                                r_rx_valid <= 1'b1;
                                if (r_state == READ_ADD)
                                    r_rd_addr_pending <= 1'b1;
                                if (r_state == READ_DATA) begin
                                    r_rd_addr_pending <= 1'b0;
                                    r_wait_tx         <= 1'b1;
                                end
                            end
                        end else if (w_ser_load) begin
                            r_wait_tx <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    spi_miso_ser u_miso_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_ser_load),
        .i_abort (bus.SS_n),
        .i_data  (bus.tx_data),
        .o_miso  (w_miso),
        .o_done  (w_ser_done)
    );

    assign bus.MISO     = w_miso;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;

`ifdef SPI_SLAVE_SVA_EN
    a_rx_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        r_rx_valid |=> !r_rx_valid);
    a_rx_valid_full_frame: assert property (@(posedge clk) disable iff (!rst_n)
        r_rx_valid |-> (r_bit_cnt == FRAME_END));
    a_miso_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        w_ser_done |-> !w_miso);
    a_rd_data_entry: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == READ_DATA && $past(r_state) != READ_DATA) |-> $past(r_rd_addr_pending));
    a_ss_abort: assert property (@(posedge clk) disable iff (!rst_n)
        bus.SS_n |=> (r_state == IDLE));

    c_idle_chk:    cover property (@(posedge clk) r_state == IDLE    ##1 r_state == CHK_CMD);
    c_chk_write:   cover property (@(posedge clk) r_state == CHK_CMD ##1 r_state == WRITE);
    c_chk_rd_add:  cover property (@(posedge clk) r_state == CHK_CMD ##1 r_state == READ_ADD);
    c_chk_rd_data: cover property (@(posedge clk) r_state == CHK_CMD ##1 r_state == READ_DATA);
    c_abort_chk:   cover property (@(posedge clk) r_state == CHK_CMD   && bus.SS_n);
    c_abort_write: cover property (@(posedge clk) r_state == WRITE     && bus.SS_n);
    c_abort_rdadd: cover property (@(posedge clk) r_state == READ_ADD  && bus.SS_n);
    c_abort_rddat: cover property (@(posedge clk) r_state == READ_DATA && bus.SS_n);
    c_abort_shift: cover property (@(posedge clk) !w_ser_done && bus.SS_n);
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_ctrl : directed vector table plus hand-written corner sequences
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_slave_ctrl;
    import spi_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_ctrl_if bus ();

    spi_slave_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [9:0] frame;
        int         extra;
        bit         is_rd;
        logic [7:0] tx;
        logic [9:0] exp_rx;
        spi_state_e exp_state;
        bit         exp_pend;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t       vecs [8];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         n_valid = 0;
    int         last_rx_cyc = -1;
    logic [9:0] last_rx = '0;
    int         nb;
    int         e10;
    logic [7:0] got;
    logic [9:0] f;
    bit         bad;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            n_valid     = n_valid + 1;
            last_rx_cyc = cyc;
            last_rx     = bus.rx_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [9:0] fr, input int extra, output int edge10);
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            bus.MOSI = fr[i];
        end
        edge10 = cyc + 1;
        @(negedge clk);
        for (int i = 0; i < extra; i++) begin
            bus.MOSI = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic end_frame();
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        @(negedge clk);
        #1;
    endtask

    // Called one cycle before tx_valid should be raised; returns the 8 MISO bits.
    task automatic answer_read(input logic [7:0] data, output logic [7:0] bits);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = data;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        for (int k = 7; k >= 0; k--) begin
            #1;
            bits[k] = bus.MISO;
            @(negedge clk);
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{10'h0A5, 0, 1'b0, 8'h00, 10'h0A5, WRITE,     1'b0, 8'h00};
        vecs[1] = '{10'h13C, 0, 1'b0, 8'h00, 10'h13C, WRITE,     1'b0, 8'h00};
        vecs[2] = '{10'h2A5, 0, 1'b0, 8'h00, 10'h2A5, READ_ADD,  1'b1, 8'h00};
        vecs[3] = '{10'h1F0, 0, 1'b0, 8'h00, 10'h1F0, WRITE,     1'b1, 8'h00};
        vecs[4] = '{10'h300, 0, 1'b1, 8'h5C, 10'h300, READ_DATA, 1'b0, 8'b0101_1100};
        vecs[5] = '{10'h2FF, 0, 1'b0, 8'h00, 10'h2FF, READ_ADD,  1'b1, 8'h00};
        vecs[6] = '{10'h3AB, 0, 1'b1, 8'hA3, 10'h3AB, READ_DATA, 1'b0, 8'b1010_0011};
        vecs[7] = '{10'h155, 3, 1'b0, 8'h00, 10'h155, WRITE,     1'b0, 8'h00};

        bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_miso",     32'(bus.MISO), 32'd0);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_rx_data",  32'(bus.rx_data), 32'd0);
        check("reset_state",    32'(dut.r_state), 32'(IDLE));
        check("reset_pending",  32'(dut.r_rd_addr_pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            nb = n_valid;
            send_frame(vecs[v].frame, vecs[v].extra, e10);
            #1;
            check($sformatf("v%0d_rx_data", v), 32'(last_rx), 32'(vecs[v].exp_rx));
            check($sformatf("v%0d_latency", v), 32'(last_rx_cyc), 32'(e10));
            check($sformatf("v%0d_state", v), 32'(dut.r_state), 32'(vecs[v].exp_state));
            check($sformatf("v%0d_pending", v), 32'(dut.r_rd_addr_pending), 32'(vecs[v].exp_pend));
            if (vecs[v].is_rd) begin
                check($sformatf("v%0d_miso_pre", v), 32'(bus.MISO), 32'd0);
                answer_read(vecs[v].tx, got);
                check($sformatf("v%0d_miso_bits", v), 32'(got), 32'(vecs[v].exp_miso));
                check($sformatf("v%0d_miso_tail", v), 32'(bus.MISO), 32'd0);
            end
            end_frame();
            check($sformatf("v%0d_pulses", v), 32'(n_valid), 32'(nb + 1));
            check($sformatf("v%0d_idle", v), 32'(dut.r_state), 32'(IDLE));
        end

        // Abort a write after 5 bits, with stray tx_valid held high.
        nb = n_valid;
        f  = 10'h0A5;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        @(negedge clk);
        bus.SS_n = 1'b0;
        for (int i = 9; i >= 5; i--) begin
            @(negedge clk);
            bus.MOSI = f[i];
        end
        @(negedge clk);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        @(negedge clk);
        #1;
        check("abort_state", 32'(dut.r_state), 32'(IDLE));
        check("abort_cnt",   32'(dut.r_bit_cnt), 32'd0);
        check("abort_miso",  32'(bus.MISO), 32'd0);
        check("abort_no_rx", 32'(n_valid), 32'(nb));
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        send_frame(10'h0FF, 0, e10);
        #1;
        check("after_abort_rx",      32'(last_rx), 32'h0FF);
        check("after_abort_latency", 32'(last_rx_cyc), 32'(e10));
        end_frame();
        check("after_abort_pulses", 32'(n_valid), 32'(nb + 1));

        // Read-data with the RAM response withheld for 20 cycles.
        send_frame(10'h255, 0, e10);
        #1;
        check("wh_addr_pending", 32'(dut.r_rd_addr_pending), 32'd1);
        end_frame();
        nb = n_valid;
        send_frame(10'h3C3, 0, e10);
        #1;
        check("wh_rx_data", 32'(last_rx), 32'h3C3);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (bus.MISO !== 1'b0 || dut.r_state != READ_DATA) bad = 1'b1;
        end
        check("wh_quiet_hold", 32'(bad), 32'd0);
        answer_read(8'h81, got);
        check("wh_miso_bits",  32'(got), 32'b1000_0001);
        check("wh_miso_tail",  32'(bus.MISO), 32'd0);
        check("wh_pending",    32'(dut.r_rd_addr_pending), 32'd0);
        end_frame();
        check("wh_pulses", 32'(n_valid), 32'(nb + 1));

        // Asynchronous reset in the middle of a read-data frame.
        send_frame(10'h2A5, 0, e10);
        end_frame();
        nb = n_valid;
        f  = 10'h300;
        @(negedge clk);
        bus.SS_n = 1'b0;
        for (int i = 9; i >= 6; i--) begin
            @(negedge clk);
            bus.MOSI = f[i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_state",    32'(dut.r_state), 32'(IDLE));
        check("mrst_cnt",      32'(dut.r_bit_cnt), 32'd0);
        check("mrst_pending",  32'(dut.r_rd_addr_pending), 32'd0);
        check("mrst_rx_data",  32'(bus.rx_data), 32'd0);
        check("mrst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("mrst_miso",     32'(bus.MISO), 32'd0);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("mrst_no_rx",    32'(n_valid), 32'(nb));
        check("mrst_idle",     32'(dut.r_state), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
